// File: rtl/regfile.sv
// Integer register file with two combinational read ports and one write port.
// x0 has no storage and always reads zero; reads see a same-cycle write through the bypass.
module regfile #(
  parameter int WORD_SIZE = 32,
  parameter int NUM_REGS  = 32,
  parameter int REG_SEL   = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_SEL-1:0]   rs1,
  output logic [WORD_SIZE-1:0] rs1Data,
  input  logic [REG_SEL-1:0]   rs2,
  output logic [WORD_SIZE-1:0] rs2Data,
  input  logic                 wCtrl,
  input  logic [REG_SEL-1:0]   wSel,
  input  logic [WORD_SIZE-1:0] wData
);

  logic [WORD_SIZE-1:0] regs_q [1:NUM_REGS-1];
  logic [WORD_SIZE-1:0] regs_d [1:NUM_REGS-1];
  logic                 wen_d;

  // Reset masks the write so neither storage nor the bypass see it.
  assign wen_d = wCtrl & ~rst;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
    always_comb begin
      regs_d[i] = regs_q[i];
      if (wen_d && (wSel == REG_SEL'(i))) regs_d[i] = wData;
    end

    always_ff @(posedge clk) begin
      if (rst) regs_q[i] <= '0;
      else     regs_q[i] <= regs_d[i];
    end
  end

  // Only selects in 1..NUM_REGS-1 can hit, so x0 and out-of-range selects read zero.
  function automatic logic [WORD_SIZE-1:0] rd_port(input logic [REG_SEL-1:0] sel);
    logic [WORD_SIZE-1:0] val;
    val = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (sel == REG_SEL'(i)) val = (wen_d && (wSel == sel)) ? wData : regs_q[i];
    end
    return val;
  endfunction

  always_comb begin
    rs1Data = rd_port(rs1);
    rs2Data = rd_port(rs2);
  end

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: a per-cycle model comparison plus literal read checks.
module tb_regfile;
  localparam int W = 32;
  localparam int N = 32;
  localparam int S = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [S-1:0] rs1 = '0, rs2 = '0, wSel = '0;
  logic [W-1:0] rs1Data, rs2Data, wData = '0;
  logic         wCtrl = 1'b0;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;
  logic [W-1:0] model [N];

  regfile #(.WORD_SIZE(W), .NUM_REGS(N)) dut (
    .clk(clk), .rst(rst),
    .rs1(rs1), .rs1Data(rs1Data),
    .rs2(rs2), .rs2Data(rs2Data),
    .wCtrl(wCtrl), .wSel(wSel), .wData(wData)
  );

  always #5 clk = ~clk;

  // Architectural model: array state updated at each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) model[i] = '0;
      started = 1'b1;
    end else if (wCtrl && wSel != 0) begin
      model[wSel] = wData;
    end
  end

  function automatic logic [W-1:0] expect_rd(input logic [S-1:0] sel);
    if (sel == 0) return '0;
    if (!rst && wCtrl && wSel == sel) return wData;
    return model[sel];
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("model_rs1", rs1Data, expect_rd(rs1));
      check("model_rs2", rs2Data, expect_rd(rs2));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [S-1:0] sel, input logic [W-1:0] d);
    wCtrl = 1'b1; wSel = sel; wData = d;
    cyc();
  endtask

  task automatic rd(input string name, input logic [S-1:0] a, input logic [S-1:0] b,
                    input logic [W-1:0] ea, input logic [W-1:0] eb);
    rs1 = a; rs2 = b;
    #1;
    check({name, "_rs1"}, rs1Data, ea);
    check({name, "_rs2"}, rs2Data, eb);
  endtask

  initial begin
    cyc(); cyc();
    rst = 1'b0;
    rd("reset", 12, 31, 32'h0, 32'h0);

    wr(12, 32'hDEADBEEF); wCtrl = 1'b0; cyc();
    wr(3, 32'hABCDABCD);  wCtrl = 1'b0;
    rd("t1", 12, 3, 32'hDEADBEEF, 32'hABCDABCD);

    wr(0, 32'h87654321); wCtrl = 1'b0;
    rd("t2", 3, 0, 32'hABCDABCD, 32'h0);

    wr(12, 32'h01010101); wr(31, 32'hFFFFFFFF); wCtrl = 1'b0;
    rd("t3", 12, 31, 32'h01010101, 32'hFFFFFFFF);

    wr(16, 32'hFEFEFE00); wr(19, 32'h00088800); wCtrl = 1'b0;
    rd("t4", 16, 19, 32'hFEFEFE00, 32'h00088800);

    wCtrl = 1'b1; wSel = 7; wData = 32'h12345678;
    rd("t5_bypass", 7, 16, 32'h12345678, 32'hFEFEFE00);
    cyc(); wCtrl = 1'b0;
    rd("t5_after", 7, 7, 32'h12345678, 32'h12345678);

    // Bypass must not resurrect x0.
    wCtrl = 1'b1; wSel = 0; wData = 32'h55AA55AA;
    rd("x0_bypass", 0, 19, 32'h0, 32'h00088800);
    cyc(); wCtrl = 1'b0;

    wr(9, 32'h00000001); wr(9, 32'h00000002); wCtrl = 1'b0;
    rd("same_reg", 9, 9, 32'h00000002, 32'h00000002);

    for (int i = 1; i < N; i++) wr(S'(i), 32'h01010101 * i);
    wCtrl = 1'b0;
    rd("sweep", 1, 30, 32'h01010101, 32'h1E1E1E1E);
    for (int i = 0; i < N; i++) begin
      rs1 = S'(i); rs2 = S'(N - 1 - i);
      cyc();
    end

    // Reset with a concurrent write: bypass suppressed and write dropped.
    rst = 1'b1; wCtrl = 1'b1; wSel = 5; wData = 32'hCAFEF00D;
    rd("t6_during", 5, 12, 32'h05050505, 32'h0C0C0C0C);
    cyc();
    rst = 1'b0; wCtrl = 1'b0;
    rd("t6", 5, 12, 32'h0, 32'h0);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- General-purpose integer register file for the RISC-V core datapath: two read ports, one write port, register 0 hardwired to zero.
- Sits between decode (rs1/rs2 selects), execute (operands) and writeback (wCtrl/wSel/wData).
- Reads are combinational with same-cycle write bypass. Writes commit on the rising clock edge.

Parameters:
- WORD_SIZE, 32, data width of each register and of every data port.
- NUM_REGS, 32, number of architectural registers, including x0.
- REG_SEL, $clog2(NUM_REGS), width of every register-select port.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rs1  in  REG_SEL  read port 1 register select.
- rs1Data  out  WORD_SIZE  read port 1 data.
- rs2  in  REG_SEL  read port 2 register select.
- rs2Data  out  WORD_SIZE  read port 2 data.
- wCtrl  in  1  write enable.
- wSel  in  REG_SEL  write register select.
- wData  in  WORD_SIZE  write data.

Behaviour:
- Storage: NUM_REGS-1 registers of WORD_SIZE bits, indices 1..NUM_REGS-1. No storage for index 0.
- Reset:
  - On a rising edge with rst=1, all stored registers clear to 0.
  - Reset has priority over a simultaneous write; the write is discarded.
  - Reset asserted mid-operation takes effect at the next edge; no partial state is kept.
- Write:
  - On a rising edge with rst=0, wCtrl=1, wSel!=0 and wSel<NUM_REGS, reg[wSel] <= wData.
  - wCtrl=0 leaves all state unchanged; wSel and wData are don't-care.
  - A write to index 0 is silently ignored.
  - A write to an index >= NUM_REGS is silently ignored; this only matters when NUM_REGS is not a power of 2.
- Read (both ports independent and identical, purely combinational, zero-cycle latency):
  - If the select is 0 or >= NUM_REGS, the output is 0.
  - Else, if rst=0, wCtrl=1 and wSel equals the select, the output is wData (write-through bypass, so same-cycle writeback is visible).
  - Else, the output is the stored reg[select].
- Both ports may select the same register; each returns the same value.
- Read ports change only in response to selects, stored state or the bypass path. No clock-to-output register on reads.
- After reset, every read returns 0 until that register is written.
- Back-to-back writes on consecutive edges to different registers both commit; no idle cycle is required.
- Two writes to the same register on consecutive edges: the later one wins.
- No X propagation: outputs are defined for all select values after the first reset edge.

Test Plan:
1. Reset, then write x12=0xDEADBEEF and x3=0xABCDABCD with one idle cycle between writes. Read rs1=12, rs2=3 -> rs1Data=0xDEADBEEF, rs2Data=0xABCDABCD.
2. Write x0=0x87654321. Read rs1=3, rs2=0 -> rs1Data=0xABCDABCD, rs2Data=0x00000000.
3. Overwrite x12=0x01010101 and write x31=0xFFFFFFFF. Read rs1=12, rs2=31 -> rs1Data=0x01010101, rs2Data=0xFFFFFFFF.
4. Back-to-back writes on consecutive edges: x16=0xFEFEFE00, then x19=0x00088800. Deassert wCtrl, read rs1=16, rs2=19 -> 0xFEFEFE00 and 0x00088800.
5. Bypass: hold wCtrl=1, wSel=7, wData=0x12345678 with rs1=7 before the edge -> rs1Data=0x12345678 combinationally. After the edge with wCtrl=0 -> still 0x12345678.
6. Reset priority: assert rst together with wCtrl=1, wSel=5, wData=0xCAFEF00D. After the edge, deassert both and read rs1=5, rs2=12 -> both 0x00000000.
